cw_perm_fwd: RTL and testbench



---
 rtl/osd_perm_pkg.sv | 21 ++
 rtl/perm_lane.sv | 35 +++
 rtl/cw_perm_fwd.sv | 184 ++++++++++++++++++
 tb/tb_cw_perm_fwd.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/osd_perm_pkg.sv
// Shared constants, FSM state type and sizing helpers for the OSD permutation stages.
package osd_perm_pkg;

   localparam int unsigned OSD_N = 64;
   localparam int unsigned OSD_W = $clog2(OSD_N);
   localparam int unsigned OSD_P = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } perm_state_e;

   // Width of the RUN-cycle counter: clog2(n/p), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n, input int unsigned p);
      int unsigned w;
      w = $clog2(n / p);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/perm_lane.sv
// One lane of the forward permutation: lambda2 entry -> lambda1 entry -> codeword bit.
// Any index outside 0..N-1 at either level produces bit 0 and raises oor_c.
module perm_lane
   import osd_perm_pkg::*;
#(
   parameter int unsigned N = OSD_N,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0]        codeword,
   input  logic [N-1:0][W-1:0] lambda1,
   input  logic [W-1:0]        sel,
   output logic                bit_c,
   output logic [W-1:0]        idx_c,
   output logic                oor_c
);

   logic         in2;
   logic         in1;
   logic [W-1:0] sel_s;
   logic [W-1:0] ent1;
   logic [W-1:0] ent1_s;

   // Two-level lookup with out-of-range indices forced to a safe zero address.
   always_comb begin
      in2    = 32'(sel) < N;
      sel_s  = in2 ? sel : '0;
      ent1   = lambda1[sel_s];
      in1    = 32'(ent1) < N;
      ent1_s = in1 ? ent1 : '0;
      idx_c  = ent1_s;
      oor_c  = !(in1 && in2);
      bit_c  = in1 && in2 && codeword[ent1_s];
   end

endmodule

// File: rtl/cw_perm_fwd.sv
// Forward codeword permutation: perm[m] = codeword[lambda1[lambda2[m]]], P bits per cycle.
// Optional duplicate/out-of-range detection on the composed map: CW_PERM_FWD_CHECK_EN.
module cw_perm_fwd
   import osd_perm_pkg::*;
#(
   parameter int unsigned N = OSD_N,
   parameter int unsigned W = $clog2(N),
   parameter int unsigned P = OSD_P
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   codeword_flat,
   input  logic [N*W-1:0] lambda1_flat,
   input  logic [N*W-1:0] lambda2_flat,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   perm_flat,
   output logic           busy,
   output logic           perm_err
);

   localparam int unsigned  CW       = cnt_width(N, P);
   localparam logic [CW-1:0] CNT_LAST = CW'(N / P - 1);

   if (N % P != 0) begin : g_bad_p
      $error("cw_perm_fwd: N must be a multiple of P");
   end

   perm_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [N-1:0]         res_q, res_d;
   logic [N-1:0]         cw_q, cw_d;
   logic [N-1:0][W-1:0]  l1_q, l1_d;
   logic [N-1:0][W-1:0]  l2_q, l2_d;
   logic                 in_ready_d;
   logic                 out_valid_d;
   logic                 busy_d;

   logic [P-1:0][W-1:0]  lane_m;
   logic [P-1:0]         lane_bit_c;
   logic [P-1:0][W-1:0]  lane_idx_c;
   logic [P-1:0]         lane_oor_c;

   // Lane p handles output position cnt*P + p this cycle.
   for (genvar p = 0; p < int'(P); p++) begin : g_lane
      assign lane_m[p] = W'(32'(cnt_q) * P + 32'(p));

      perm_lane #(.N(N), .W(W)) u_lane (
         .codeword (cw_q),
         .lambda1  (l1_q),
         .sel      (l2_q[lane_m[p]]),
         .bit_c    (lane_bit_c[p]),
         .idx_c    (lane_idx_c[p]),
         .oor_c    (lane_oor_c[p])
      );
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      cw_d        = cw_q;
      l1_d        = l1_q;
      l2_d        = l2_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               cw_d    = codeword_flat;
               l1_d    = lambda1_flat;
               l2_d    = lambda2_flat;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int p = 0; p < int'(P); p++) begin
               res_d[lane_m[p]] = lane_bit_c[p];
            end
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State, captured job and output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         res_q     <= '0;
         cw_q      <= '0;
         l1_q      <= '0;
         l2_q      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         cw_q      <= cw_d;
         l1_q      <= l1_d;
         l2_q      <= l2_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;
      end
   end

   assign perm_flat = res_q;

`ifdef CW_PERM_FWD_CHECK_EN
   logic [N-1:0] seen_q, seen_d;
   logic         err_q, err_d;
   logic         perm_err_q, perm_err_d;

   // Track composed indices; a repeat (also between lanes of one cycle) or out-of-range is an error.
   always_comb begin
      seen_d     = seen_q;
      err_d      = err_q;
      perm_err_d = perm_err_q;
      if (state_q == IDLE && in_valid) begin
         seen_d     = '0;
         err_d      = 1'b0;
         perm_err_d = 1'b0;
      end else if (state_q == RUN) begin
         for (int p = 0; p < int'(P); p++) begin
            if (lane_oor_c[p]) begin
               err_d = 1'b1;
            end else begin
               if (seen_d[lane_idx_c[p]]) begin
                  err_d = 1'b1;
               end
               seen_d[lane_idx_c[p]] = 1'b1;
            end
         end
         if (cnt_q == CNT_LAST) begin
            perm_err_d = err_d;
         end
      end
   end

   // Checker state; perm_err updates together with the move into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q     <= '0;
         err_q      <= 1'b0;
         perm_err_q <= 1'b0;
      end else begin
         seen_q     <= seen_d;
         err_q      <= err_d;
         perm_err_q <= perm_err_d;
      end
   end

   assign perm_err = perm_err_q;
`else
   logic unused_chk;
   assign unused_chk = ^{lane_idx_c, lane_oor_c};
   assign perm_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cw_perm_fwd.sv
// Directed bench for cw_perm_fwd with a map-level reference model and a per-cycle output checker.
module tb_cw_perm_fwd;

   localparam int N = 64;
   localparam int W = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [N-1:0]   codeword_flat = '0;
   logic [N*W-1:0] lambda1_flat = '0;
   logic [N*W-1:0] lambda2_flat = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N-1:0]   perm_flat;
   logic           busy;
   logic           perm_err;

   int n_chk  = 0;
   int n_pass = 0;

   int          l1 [N];
   int          l2 [N];
   logic [63:0] cw_v;
   logic [63:0] exp_perm = '0;
   logic        exp_err = 1'b0;
   logic [63:0] last_perm;

   cw_perm_fwd u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .codeword_flat (codeword_flat),
      .lambda1_flat  (lambda1_flat),
      .lambda2_flat  (lambda2_flat),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .perm_flat     (perm_flat),
      .busy          (busy),
      .perm_err      (perm_err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, exp);
   endtask

   // Reference: out[m] = cw[l1[l2[m]]], zero for any out-of-range index.
   function automatic logic [63:0] model_perm();
      logic [63:0] r;
      r = '0;
      for (int m = 0; m < N; m++) begin
         if (l2[m] < N && l1[l2[m]] < N) r[m] = cw_v[l1[l2[m]]];
      end
      return r;
   endfunction

   function automatic logic model_err();
`ifdef CW_PERM_FWD_CHECK_EN
      bit seen [N];
      logic e;
      e = 1'b0;
      for (int m = 0; m < N; m++) begin
         if (l2[m] >= N || l1[l2[m]] >= N) e = 1'b1;
         else if (seen[l1[l2[m]]]) e = 1'b1;
         else seen[l1[l2[m]]] = 1'b1;
      end
      return e;
`else
      return 1'b0;
`endif
   endfunction

   task automatic ident_maps();
      for (int k = 0; k < N; k++) begin
         l1[k] = k;
         l2[k] = k;
      end
   endtask

   task automatic shuffle_maps();
      int j, t;
      ident_maps();
      for (int k = N - 1; k > 0; k--) begin
         j = $urandom_range(k, 0);
         t = l1[k]; l1[k] = l1[j]; l1[j] = t;
         j = $urandom_range(k, 0);
         t = l2[k]; l2[k] = l2[j]; l2[j] = t;
      end
   endtask

   // Present a job in IDLE, take the accept edge, then scramble the inputs.
   task automatic accept();
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("accept_ready", 64'(in_ready), 64'd1);
      exp_perm = model_perm();
      exp_err  = model_err();
      codeword_flat = cw_v;
      for (int k = 0; k < N; k++) begin
         lambda1_flat[k*W +: W] = W'(l1[k]);
         lambda2_flat[k*W +: W] = W'(l2[k]);
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid      = 1'b0;
      codeword_flat = ~codeword_flat;
      lambda1_flat  = ~lambda1_flat;
      lambda2_flat  = ~lambda2_flat;
   endtask

   // Full job: latency (accept edge counted as 1), optional backpressure hold, exit to IDLE.
   task automatic run_job(input int hold, input bit use_lit, input logic [63:0] lit);
      int  lat;
      bit  got;
      accept();
      out_ready = (hold == 0);
      lat = 1;
      got = 0;
      while (!got && lat < 30) begin
         if (out_valid) got = 1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("latency", 64'(lat), 64'd9);
      last_perm = perm_flat;
      if (use_lit) chk("literal_perm", perm_flat, lit);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("hold_valid", 64'(out_valid), 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("exit_flags", {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   // Per-cycle output check whenever a result is presented.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("perm", perm_flat, exp_perm);
         chk("done_flags", {62'd0, busy, in_ready}, 64'b10);
         chk("perm_err", 64'(perm_err), 64'(exp_err));
      end
   end

   initial begin
      logic [63:0] rec;

      #12;
      chk("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
      chk("rst_perm", perm_flat, 64'd0);
      chk("rst_err", 64'(perm_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Identity maps pass the codeword through unchanged.
      ident_maps();
      cw_v = 64'hDEADBEEF_01234567;
      run_job(0, 1'b1, 64'hDEADBEEF_01234567);

      // lambda1 reversal: bit 0 moves to bit 63.
      for (int k = 0; k < N; k++) l1[k] = N - 1 - k;
      cw_v = 64'h1;
      run_job(0, 1'b1, 64'h8000_0000_0000_0000);

      // Backpressure: 20 cycles in DONE with in_valid pulsed and ignored.
      shuffle_maps();
      cw_v = {$urandom, $urandom};
      run_job(20, 1'b0, '0);

      // Duplicate composed index: lambda2[5] = lambda2[6] = 3.
      ident_maps();
      l2[5] = 3;
      l2[6] = 3;
      cw_v = 64'hDEADBEEF_01234567;
      run_job(0, 1'b1, 64'hDEADBEEF_01234507);
`ifdef CW_PERM_FWD_CHECK_EN
      chk("dup_err_after", 64'(perm_err), 64'd1);
`endif
      ident_maps();
      cw_v = 64'h0F0F_1234_5678_9ABC;
      run_job(0, 1'b1, 64'h0F0F_1234_5678_9ABC);
      chk("clean_err_after", 64'(perm_err), 64'd0);

      // Reset at cnt=4 discards the job.
      shuffle_maps();
      cw_v = 64'hFFFF_FFFF_FFFF_FFFF;
      accept();
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
      chk("midrst_perm", perm_flat, 64'd0);
      chk("midrst_err", 64'(perm_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      ident_maps();
      for (int k = 0; k < N; k++) l1[k] = N - 1 - k;
      cw_v = 64'h1;
      run_job(0, 1'b1, 64'h8000_0000_0000_0000);

      // Round trip through the inverse maps over random jobs.
      for (int j = 0; j < 1000; j++) begin
         shuffle_maps();
         cw_v = {$urandom, $urandom};
         run_job(0, 1'b0, '0);
         rec = '0;
         for (int m = 0; m < N; m++) rec[l1[l2[m]]] = last_perm[m];
         chk("roundtrip", rec, cw_v);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
